// File: rtl/swerv_types_pkg.sv
// Shared trigger types, CSR addresses, mcontrol field positions and helpers.
// TRIGGER_HITCNT_EN (optional) enables per-trigger hit counters at CSR 0x7C8.
package swerv_types_pkg;

    localparam int NUM_TRIG = 4;
    localparam int TSEL_W   = 2;

    localparam logic [11:0] CSR_TSELECT = 12'h7A0;
    localparam logic [11:0] CSR_TDATA1  = 12'h7A1;
    localparam logic [11:0] CSR_TDATA2  = 12'h7A2;
    localparam logic [11:0] CSR_HITCNT  = 12'h7C8;

    localparam logic [31:0] TDATA1_RST = 32'h23E0_0000;

    localparam int MC_DMODE     = 27;
    localparam int MC_HIT       = 20;
    localparam int MC_SELECT    = 19;
    localparam int MC_ACTION_HI = 15;
    localparam int MC_ACTION_LO = 12;
    localparam int MC_CHAIN     = 11;
    localparam int MC_MATCH_HI  = 10;
    localparam int MC_MATCH_LO  = 7;
    localparam int MC_M         = 6;
    localparam int MC_EXEC      = 2;
    localparam int MC_STORE     = 1;
    localparam int MC_LOAD      = 0;

    typedef struct packed {
        logic        select;
        logic        match;
        logic        store;
        logic        load;
        logic        execute;
        logic        m;
        logic [31:0] tdata2;
    } trigger_pkt_t;

    // Only the legal encodings are stored: match and action collapse to one bit each.
    typedef struct packed {
        logic dmode;
        logic hit;
        logic select;
        logic action;
        logic chain;
        logic match;
        logic m;
        logic execute;
        logic store;
        logic load;
    } mcontrol_t;

    function automatic logic [31:0] mc_pack(input mcontrol_t mc);
        logic [31:0] v;
        v               = TDATA1_RST;
        v[MC_DMODE]     = mc.dmode;
        v[MC_HIT]       = mc.hit;
        v[MC_SELECT]    = mc.select;
        v[MC_ACTION_LO] = mc.action;
        v[MC_CHAIN]     = mc.chain;
        v[MC_MATCH_LO]  = mc.match;
        v[MC_M]         = mc.m;
        v[MC_EXEC]      = mc.execute;
        v[MC_STORE]     = mc.store;
        v[MC_LOAD]      = mc.load;
        return v;
    endfunction

    function automatic mcontrol_t mc_legalize(input mcontrol_t raw, input logic old_dmode,
                                              input logic dbg, input logic odd);
        mcontrol_t mc;
        mc        = raw;
        mc.dmode  = dbg ? raw.dmode : old_dmode;
        mc.action = raw.action & mc.dmode;
        mc.chain  = raw.chain & ~odd;
        return mc;
    endfunction

endpackage

// File: rtl/lsu_trigger_chain.sv
// Pair qualification of the dc5 match vector: a chained even trigger fires
// together with its odd partner or not at all.
module lsu_trigger_chain
    import swerv_types_pkg::*;
(
    input  logic [NUM_TRIG-1:0] match_dc5,
    input  logic [NUM_TRIG-1:0] chain,
    output logic [NUM_TRIG-1:0] qual_dc5
);

    logic [NUM_TRIG/2-1:0] pair_fire_s;
    logic [NUM_TRIG/2-1:0] unused_chain_odd_s;

    for (genvar p = 0; p < NUM_TRIG/2; p++) begin : g_pair
        assign pair_fire_s[p]        = match_dc5[2*p] & match_dc5[2*p+1];
        assign qual_dc5[2*p]         = chain[2*p] ? pair_fire_s[p] : match_dc5[2*p];
        assign qual_dc5[2*p+1]       = chain[2*p] ? pair_fire_s[p] : match_dc5[2*p+1];
        assign unused_chain_odd_s[p] = chain[2*p+1];
    end

endmodule

// File: rtl/lsu_trigger_ctl.sv
// Debug trigger CSRs, LSU trigger packets and the dc3->dc5 trigger hit pipeline.
// Optional hit counters are built when TRIGGER_HITCNT_EN is defined.
module lsu_trigger_ctl
    import swerv_types_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst_l,
    input  logic                               dbg_mode,
    input  logic                               csr_wr_en,
    input  logic [11:0]                        csr_wr_addr,
    input  logic [31:0]                        csr_wr_data,
    input  logic [11:0]                        csr_rd_addr,
    output logic [31:0]                        csr_rd_data,
    output trigger_pkt_t [NUM_TRIG-1:0]        trigger_pkt_any,
    input  logic                               lsu_valid_dc3,
    input  logic [NUM_TRIG-1:0]                lsu_trigger_match_dc3,
    input  logic                               flush_dc4,
    input  logic                               flush_dc5,
    output logic [NUM_TRIG-1:0]                trigger_hit_dc5,
    output logic                               trigger_brk_req,
    output logic                               trigger_dbg_req
);

    logic [TSEL_W-1:0]              tselect_q, tselect_d;
    mcontrol_t [NUM_TRIG-1:0]       tdata1_q, tdata1_d;
    logic [NUM_TRIG-1:0][31:0]      tdata2_q, tdata2_d;
    logic [NUM_TRIG-1:0]            dc4_q, dc4_d;
    logic [NUM_TRIG-1:0]            dc5_q, dc5_d;

    logic                           wr_tsel_s;
    logic                           wr_t1_s;
    logic                           wr_t2_s;
    logic [NUM_TRIG-1:0]            sel_ok_s;
    logic [NUM_TRIG-1:0]            chain_s;
    logic [NUM_TRIG-1:0]            action_s;
    logic [NUM_TRIG-1:0]            qual_dc5_s;
    mcontrol_t                      wr_mc_s;
    logic                           unused_wr_data_s;

    assign wr_tsel_s        = csr_wr_en & (csr_wr_addr == CSR_TSELECT);
    assign wr_t1_s          = csr_wr_en & (csr_wr_addr == CSR_TDATA1);
    assign wr_t2_s          = csr_wr_en & (csr_wr_addr == CSR_TDATA2);
    assign unused_wr_data_s = ^csr_wr_data;

    // Raw write data decoded into mcontrol fields; illegal match/action encodings become 0.
    always_comb begin
        wr_mc_s         = '0;
        wr_mc_s.dmode   = csr_wr_data[MC_DMODE];
        wr_mc_s.hit     = csr_wr_data[MC_HIT];
        wr_mc_s.select  = csr_wr_data[MC_SELECT];
        wr_mc_s.action  = (csr_wr_data[MC_ACTION_HI:MC_ACTION_LO] == 4'd1);
        wr_mc_s.chain   = csr_wr_data[MC_CHAIN];
        wr_mc_s.match   = (csr_wr_data[MC_MATCH_HI:MC_MATCH_LO] == 4'd1);
        wr_mc_s.m       = csr_wr_data[MC_M];
        wr_mc_s.execute = csr_wr_data[MC_EXEC];
        wr_mc_s.store   = csr_wr_data[MC_STORE];
        wr_mc_s.load    = csr_wr_data[MC_LOAD];
    end

    // Per-trigger write select, blocked for debug-owned triggers outside debug mode.
    always_comb begin
        for (int i = 0; i < NUM_TRIG; i++) begin
            sel_ok_s[i] = (tselect_q == TSEL_W'(i)) & ~(tdata1_q[i].dmode & ~dbg_mode);
            chain_s[i]  = tdata1_q[i].chain;
            action_s[i] = tdata1_q[i].action;
        end
    end

    // Next-state for tselect: out-of-range values keep the old selection.
    always_comb begin
        if (wr_tsel_s && (csr_wr_data < 32'(NUM_TRIG))) begin
            tselect_d = csr_wr_data[TSEL_W-1:0];
        end else begin
            tselect_d = tselect_q;
        end
    end

    // Next-state for tdata1/tdata2; a commit hit is OR-ed in after any write so it is never lost.
    always_comb begin
        for (int i = 0; i < NUM_TRIG; i++) begin
            if (wr_t1_s && sel_ok_s[i]) begin
                tdata1_d[i] = mc_legalize(wr_mc_s, tdata1_q[i].dmode, dbg_mode, (i % 2) == 1);
            end else begin
                tdata1_d[i] = tdata1_q[i];
            end
            tdata1_d[i].hit = tdata1_d[i].hit | trigger_hit_dc5[i];
            if (wr_t2_s && sel_ok_s[i]) begin
                tdata2_d[i] = csr_wr_data;
            end else begin
                tdata2_d[i] = tdata2_q[i];
            end
        end
    end

    // Match pipeline next-state.
    always_comb begin
        dc4_d = lsu_valid_dc3 ? lsu_trigger_match_dc3 : {NUM_TRIG{1'b0}};
        dc5_d = flush_dc4 ? {NUM_TRIG{1'b0}} : dc4_q;
    end

    // CSR and pipeline state registers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            tselect_q <= {TSEL_W{1'b0}};
            tdata1_q  <= '0;
            tdata2_q  <= '0;
            dc4_q     <= {NUM_TRIG{1'b0}};
            dc5_q     <= {NUM_TRIG{1'b0}};
        end else begin
            tselect_q <= tselect_d;
            tdata1_q  <= tdata1_d;
            tdata2_q  <= tdata2_d;
            dc4_q     <= dc4_d;
            dc5_q     <= dc5_d;
        end
    end

    lsu_trigger_chain u_chain (
        .match_dc5 (dc5_q),
        .chain     (chain_s),
        .qual_dc5  (qual_dc5_s)
    );

    // Commit qualification and request generation; debug halt outranks breakpoint.
    always_comb begin
        trigger_hit_dc5 = qual_dc5_s & ~{NUM_TRIG{flush_dc5}};
        trigger_dbg_req = |(trigger_hit_dc5 & action_s);
        trigger_brk_req = (|(trigger_hit_dc5 & ~action_s)) & ~trigger_dbg_req;
    end

    // Matcher packets decoded from the configuration registers.
    always_comb begin
        for (int i = 0; i < NUM_TRIG; i++) begin
            trigger_pkt_any[i].select  = tdata1_q[i].select;
            trigger_pkt_any[i].match   = tdata1_q[i].match;
            trigger_pkt_any[i].store   = tdata1_q[i].store & tdata1_q[i].m;
            trigger_pkt_any[i].load    = tdata1_q[i].load & tdata1_q[i].m;
            trigger_pkt_any[i].execute = tdata1_q[i].execute;
            trigger_pkt_any[i].m       = tdata1_q[i].m;
            trigger_pkt_any[i].tdata2  = tdata2_q[i];
        end
    end

`ifdef TRIGGER_HITCNT_EN
    logic [NUM_TRIG-1:0][15:0] hitcnt_q, hitcnt_d;

    // Saturating hit counters; a CSR write wins over a same-cycle increment.
    always_comb begin
        for (int i = 0; i < NUM_TRIG; i++) begin
            if (csr_wr_en && (csr_wr_addr == CSR_HITCNT) && (tselect_q == TSEL_W'(i))) begin
                hitcnt_d[i] = csr_wr_data[15:0];
            end else if (trigger_hit_dc5[i] && (hitcnt_q[i] != 16'hFFFF)) begin
                hitcnt_d[i] = hitcnt_q[i] + 16'd1;
            end else begin
                hitcnt_d[i] = hitcnt_q[i];
            end
        end
    end

    // Hit counter registers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            hitcnt_q <= '0;
        end else begin
            hitcnt_q <= hitcnt_d;
        end
    end
`endif

    // CSR read mux.
    always_comb begin
        csr_rd_data = 32'h0;
        case (csr_rd_addr)
            CSR_TSELECT: csr_rd_data = {{(32-TSEL_W){1'b0}}, tselect_q};
            CSR_TDATA1:  csr_rd_data = mc_pack(tdata1_q[tselect_q]);
            CSR_TDATA2:  csr_rd_data = tdata2_q[tselect_q];
`ifdef TRIGGER_HITCNT_EN
            CSR_HITCNT:  csr_rd_data = {16'h0, hitcnt_q[tselect_q]};
`endif
            default:     csr_rd_data = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_lsu_trigger_ctl.sv
// Scoreboard bench for lsu_trigger_ctl: stimulus queues timed expectations,
// a negedge monitor compares CSR reads, packets and commit outputs.
`timescale 1ns/1ps
module tb_lsu_trigger_ctl;
    import swerv_types_pkg::*;

    logic                        clk;
    logic                        rst_l;
    logic                        dbg_mode;
    logic                        csr_wr_en;
    logic [11:0]                 csr_wr_addr;
    logic [31:0]                 csr_wr_data;
    logic [11:0]                 csr_rd_addr;
    logic [31:0]                 csr_rd_data;
    trigger_pkt_t [NUM_TRIG-1:0] trigger_pkt_any;
    logic                        lsu_valid_dc3;
    logic [NUM_TRIG-1:0]         lsu_trigger_match_dc3;
    logic                        flush_dc4;
    logic                        flush_dc5;
    logic [NUM_TRIG-1:0]         trigger_hit_dc5;
    logic                        trigger_brk_req;
    logic                        trigger_dbg_req;

    lsu_trigger_ctl dut (
        .clk                   (clk),
        .rst_l                 (rst_l),
        .dbg_mode              (dbg_mode),
        .csr_wr_en             (csr_wr_en),
        .csr_wr_addr           (csr_wr_addr),
        .csr_wr_data           (csr_wr_data),
        .csr_rd_addr           (csr_rd_addr),
        .csr_rd_data           (csr_rd_data),
        .trigger_pkt_any       (trigger_pkt_any),
        .lsu_valid_dc3         (lsu_valid_dc3),
        .lsu_trigger_match_dc3 (lsu_trigger_match_dc3),
        .flush_dc4             (flush_dc4),
        .flush_dc5             (flush_dc5),
        .trigger_hit_dc5       (trigger_hit_dc5),
        .trigger_brk_req       (trigger_brk_req),
        .trigger_dbg_req       (trigger_dbg_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int K_RD  = 0;
    localparam int K_PKT = 1;
    localparam int K_HIT = 2;

    int          due_q[$];
    int          kind_q[$];
    int          idx_q[$];
    logic [63:0] exp_q[$];
    string       name_q[$];

    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    bit          hit_seen;
    logic [63:0] act;

    task automatic push(input int kind, input int idx, input int due, input logic [63:0] e,
                        input string n);
        kind_q.push_back(kind);
        idx_q.push_back(idx);
        due_q.push_back(due);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    function automatic logic [63:0] hitv(input logic dbg, input logic brk, input logic [3:0] h);
        return {58'h0, dbg, brk, h};
    endfunction

    function automatic logic [63:0] pktv(input logic sel, input logic mat, input logic st,
                                         input logic ld, input logic ex, input logic m,
                                         input logic [31:0] t2);
        trigger_pkt_t p;
        p.select  = sel;
        p.match   = mat;
        p.store   = st;
        p.load    = ld;
        p.execute = ex;
        p.m       = m;
        p.tdata2  = t2;
        return {26'h0, p};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        csr_wr_en   = 1'b1;
        csr_wr_addr = a;
        csr_wr_data = d;
        tick();
        csr_wr_en   = 1'b0;
        csr_wr_addr = 12'h0;
        csr_wr_data = 32'h0;
    endtask

    task automatic expect_rd(input logic [11:0] a, input logic [31:0] e, input string n);
        csr_rd_addr = a;
        push(K_RD, 0, cyc, {32'h0, e}, n);
        tick();
    endtask

    task automatic dc3(input logic [3:0] m);
        lsu_valid_dc3         = 1'b1;
        lsu_trigger_match_dc3 = m;
        tick();
        lsu_valid_dc3         = 1'b0;
        lsu_trigger_match_dc3 = 4'b0;
    endtask

    // Monitor: compare every expectation due this cycle; with none on the commit
    // outputs, they must be idle.
    always @(negedge clk) begin
        if (mon_en) begin
            hit_seen = 1'b0;
            for (int i = due_q.size() - 1; i >= 0; i--) begin
                if (due_q[i] == cyc) begin
                    case (kind_q[i])
                        K_RD:    act = {32'h0, csr_rd_data};
                        K_PKT:   act = {26'h0, trigger_pkt_any[idx_q[i]]};
                        default: begin
                            act      = {58'h0, trigger_dbg_req, trigger_brk_req, trigger_hit_dc5};
                            hit_seen = 1'b1;
                        end
                    endcase
                    checks++;
                    if (act !== exp_q[i]) begin
                        errors++;
                        $display("FAIL %s: got %h expected %h (cycle %0d)", name_q[i], act, exp_q[i], cyc);
                    end
                end else if (due_q[i] < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s: expectation never sampled (due %0d)", name_q[i], due_q[i]);
                end
                if (due_q[i] <= cyc) begin
                    due_q.delete(i);
                    kind_q.delete(i);
                    idx_q.delete(i);
                    exp_q.delete(i);
                    name_q.delete(i);
                end
            end
            if (!hit_seen) begin
                checks++;
                if ({trigger_dbg_req, trigger_brk_req, trigger_hit_dc5} !== 6'b0) begin
                    errors++;
                    $display("FAIL idle_out: got %b expected 000000 (cycle %0d)",
                             {trigger_dbg_req, trigger_brk_req, trigger_hit_dc5}, cyc);
                end
            end
        end
    end

    initial begin
        rst_l = 1'b0; dbg_mode = 1'b0; csr_wr_en = 1'b0; csr_wr_addr = 12'h0;
        csr_wr_data = 32'h0; csr_rd_addr = 12'h0; lsu_valid_dc3 = 1'b0;
        lsu_trigger_match_dc3 = 4'b0; flush_dc4 = 1'b0; flush_dc5 = 1'b0;
        repeat (3) tick();
        rst_l = 1'b1;
        tick();
        mon_en = 1'b1;

        // Reset state and tselect range check
        push(K_PKT, 0, cyc, pktv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0), "rst_pkt0");
        expect_rd(CSR_TDATA1, 32'h23E0_0000, "rst_tdata1");
        expect_rd(CSR_TDATA2, 32'h0, "rst_tdata2");
        csr_write(CSR_TSELECT, 32'd5);
        expect_rd(CSR_TSELECT, 32'h0, "tsel_oob");
        csr_write(CSR_TSELECT, 32'd3);
        expect_rd(CSR_TSELECT, 32'h3, "tsel_3");

        // Trigger 2 configuration, legalisation and packet timing
        csr_write(CSR_TSELECT, 32'd2);
        csr_write(CSR_TDATA2, 32'h1000_0000);
        push(K_PKT, 2, cyc, pktv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000_0000), "pkt_pre");
        csr_write(CSR_TDATA1, 32'h0000_1143);
        push(K_PKT, 2, cyc, pktv(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000_0000), "pkt_post");
        expect_rd(CSR_TDATA1, 32'h23E0_0043, "legalise");
        expect_rd(CSR_TDATA2, 32'h1000_0000, "tdata2_rd");
        csr_write(CSR_TDATA1, 32'h0000_0083);
        push(K_PKT, 2, cyc, pktv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000_0000), "pkt_no_m");
        csr_write(CSR_TDATA1, 32'h0000_0043);

        // Single hit and sticky bit
        push(K_HIT, 0, cyc + 2, hitv(1'b0, 1'b1, 4'b0100), "hit_t2");
        dc3(4'b0100);
        tick(); tick();
        expect_rd(CSR_TDATA1, 32'h23F0_0043, "sticky_t2");
        lsu_trigger_match_dc3 = 4'b0100;
        tick();
        lsu_trigger_match_dc3 = 4'b0;

        // Chaining and dc4/dc5 flushes
        csr_write(CSR_TSELECT, 32'd0);
        csr_write(CSR_TDATA1, 32'h0000_0800);
        expect_rd(CSR_TDATA1, 32'h23E0_0800, "chain_t0");
        csr_write(CSR_TSELECT, 32'd1);
        csr_write(CSR_TDATA1, 32'h0000_0800);
        expect_rd(CSR_TDATA1, 32'h23E0_0000, "chain_odd");
        push(K_HIT, 0, cyc + 2, hitv(1'b0, 1'b0, 4'b0000), "chain_half");
        dc3(4'b0001);
        push(K_HIT, 0, cyc + 2, hitv(1'b0, 1'b1, 4'b0011), "chain_pair");
        dc3(4'b0011);
        push(K_HIT, 0, cyc + 2, hitv(1'b0, 1'b0, 4'b0000), "flush_dc4");
        lsu_valid_dc3 = 1'b1; lsu_trigger_match_dc3 = 4'b0011;
        tick();
        lsu_valid_dc3 = 1'b0; lsu_trigger_match_dc3 = 4'b0; flush_dc4 = 1'b1;
        tick();
        flush_dc4 = 1'b0;
        push(K_HIT, 0, cyc + 2, hitv(1'b0, 1'b0, 4'b0000), "flush_dc5");
        dc3(4'b1000);
        tick();
        flush_dc5 = 1'b1;
        tick();
        flush_dc5 = 1'b0;

        // Debug-mode ownership and action priority
        dbg_mode = 1'b1;
        csr_write(CSR_TDATA1, 32'h0800_1000);
        expect_rd(CSR_TDATA1, 32'h2BE0_1000, "dmode_set");
        dbg_mode = 1'b0;
        csr_write(CSR_TDATA1, 32'h0);
        expect_rd(CSR_TDATA1, 32'h2BE0_1000, "dmode_protect");
        csr_write(CSR_TDATA2, 32'h0000_FFFF);
        expect_rd(CSR_TDATA2, 32'h0, "dmode_prot_t2");
        csr_write(CSR_TSELECT, 32'd3);
        csr_write(CSR_TDATA1, 32'h0800_1000);
        expect_rd(CSR_TDATA1, 32'h23E0_0000, "dmode_discard");
        push(K_HIT, 0, cyc + 2, hitv(1'b1, 1'b0, 4'b0011), "dbg_over_brk");
        dc3(4'b0011);
        tick(); tick();
        csr_write(CSR_TSELECT, 32'd0);
        csr_write(CSR_TDATA1, 32'h0);
        push(K_HIT, 0, cyc + 2, hitv(1'b1, 1'b0, 4'b0010), "dbg_solo");
        dc3(4'b0010);
        tick(); tick();
        csr_write(CSR_TSELECT, 32'd1);
        expect_rd(CSR_TDATA1, 32'h2BF0_1000, "sticky_t1");

        // Hit and tdata1 write on trigger 3 in the same cycle
        csr_write(CSR_TSELECT, 32'd3);
        push(K_HIT, 0, cyc + 2, hitv(1'b0, 1'b1, 4'b1000), "hit_t3");
        dc3(4'b1000);
        tick();
        csr_write(CSR_TDATA1, 32'h0000_0043);
        expect_rd(CSR_TDATA1, 32'h23F0_0043, "hit_vs_write");
        csr_write(12'h7A3, 32'hFFFF_FFFF);
        expect_rd(CSR_TDATA2, 32'h0, "unmapped_wr");
        expect_rd(12'h7A3, 32'h0, "unmapped_rd");
`ifdef TRIGGER_HITCNT_EN
        expect_rd(CSR_HITCNT, 32'h1, "hitcnt_1");
        csr_write(CSR_HITCNT, 32'h0000_FFFF);
        push(K_HIT, 0, cyc + 2, hitv(1'b0, 1'b1, 4'b1000), "hit_sat");
        dc3(4'b1000);
        tick(); tick();
        expect_rd(CSR_HITCNT, 32'h0000_FFFF, "hitcnt_sat");
        push(K_HIT, 0, cyc + 2, hitv(1'b0, 1'b1, 4'b1000), "hit_prio");
        dc3(4'b1000);
        tick();
        csr_write(CSR_HITCNT, 32'h5);
        expect_rd(CSR_HITCNT, 32'h5, "hitcnt_wr_prio");
`else
        expect_rd(CSR_HITCNT, 32'h0, "hitcnt_absent");
`endif

        repeat (4) tick();
        checks++;
        if (due_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", due_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
